// File: rtl/mem_port_arbiter.sv
// Owner-based arbiter sharing the single main-memory port between the CPU and the disk engine.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dsk_req,
    input  logic          dsk_we,
    input  logic [AW-1:0] dsk_addr,
    input  logic [DW-1:0] dsk_wdata,
    input  logic          dsk_lock,
    output logic          dsk_gnt,
    output logic          dsk_rvalid,
    output logic [DW-1:0] dsk_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic          busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [7:0]    forced_cnt
`endif
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DSK} owner_t;

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(MAX_BURST - 1);

    owner_t        owner;
    logic          last_cpu;
    logic [CW-1:0] burst_cnt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dsk_rdata_q;
    logic          cpu_acc;
    logic          dsk_acc;
    logic          burst_top;
    logic          dsk_rel;
    logic          forced_rel;

    assign cpu_gnt    = (owner == OWN_CPU) && cpu_req;
    assign dsk_gnt    = (owner == OWN_DSK) && dsk_req;
    assign cpu_acc    = cpu_gnt;
    assign dsk_acc    = dsk_gnt;
    assign busy       = (owner != OWN_NONE);
    assign burst_top  = (burst_cnt == CNT_TOP);
    assign forced_rel = dsk_acc && dsk_lock && cpu_req && burst_top;
    assign dsk_rel    = (owner == OWN_DSK) && (!dsk_req || !dsk_lock || (cpu_req && burst_top));

    // mem_q arrives the cycle after the address, so valid data is passed straight through
    assign cpu_rdata = cpu_rvalid ? mem_q : cpu_rdata_q;
    assign dsk_rdata = dsk_rvalid ? mem_q : dsk_rdata_q;

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        if (cpu_acc) begin
            mem_addr = cpu_addr;
            mem_data = cpu_wdata;
            mem_we   = cpu_we && !rst;
        end else if (dsk_acc) begin
            mem_addr = dsk_addr;
            mem_data = dsk_wdata;
            mem_we   = dsk_we && !rst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= OWN_NONE;
            last_cpu    <= 1'b0;
            burst_cnt   <= '0;
            cpu_rvalid  <= 1'b0;
            dsk_rvalid  <= 1'b0;
            cpu_rdata_q <= '0;
            dsk_rdata_q <= '0;
        end else begin
            cpu_rvalid <= cpu_acc && !cpu_we;
            dsk_rvalid <= dsk_acc && !dsk_we;
            if (cpu_rvalid) cpu_rdata_q <= mem_q;
            if (dsk_rvalid) dsk_rdata_q <= mem_q;
            case (owner)
                OWN_NONE: begin
                    if (cpu_req && dsk_req) owner <= last_cpu ? OWN_DSK : OWN_CPU;
                    else if (cpu_req)       owner <= OWN_CPU;
                    else if (dsk_req)       owner <= OWN_DSK;
                end
                OWN_CPU: begin
                    // one access per tenure; a dropped request also gives the port up
                    owner    <= dsk_req ? OWN_DSK : OWN_NONE;
                    last_cpu <= 1'b1;
                end
                OWN_DSK: begin
                    if (dsk_rel) begin
                        owner     <= cpu_req ? OWN_CPU : OWN_NONE;
                        last_cpu  <= 1'b0;
                        burst_cnt <= '0;
                    end else if (!burst_top) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end
                default: owner <= OWN_NONE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic waiting;
    assign waiting = ((owner == OWN_CPU) && dsk_req) || ((owner == OWN_DSK) && cpu_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
            forced_cnt   <= '0;
        end else begin
            if (waiting && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
            if (forced_rel && (forced_cnt != 8'hFF))   forced_cnt   <= forced_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a tenure-level model.
// Build with MEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dsk_req = 1'b0, dsk_we = 1'b0, dsk_lock = 1'b0;
    logic [AW-1:0] dsk_addr = '0;
    logic [DW-1:0] dsk_wdata = '0;
    logic          dsk_gnt, dsk_rvalid;
    logic [DW-1:0] dsk_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q = '0;
    logic          busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
    logic [7:0]    forced_cnt;
`endif

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dsk_req(dsk_req), .dsk_we(dsk_we), .dsk_addr(dsk_addr), .dsk_wdata(dsk_wdata),
        .dsk_lock(dsk_lock),
        .dsk_gnt(dsk_gnt), .dsk_rvalid(dsk_rvalid), .dsk_rdata(dsk_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
        .busy(busy)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory behind the port ----------------
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5C3);
    endfunction

    logic [DW-1:0] ram [int];
    always @(posedge clk) begin
        mem_q <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(mem_addr);
        if (mem_we) ram[int'(mem_addr)] = mem_data;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 cpu, 2 dsk; ten = accesses done in the current disk tenure
    int            m_owner, m_last, m_ten, m_conf, m_forced;
    logic          m_cpu_pend, m_dsk_pend;
    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] dsk_exp_q[$];
    logic [DW-1:0] shadow [int];
    logic          cpu_acc_flag = 1'b0, dsk_acc_flag = 1'b0;
    int            dsk_acc_n = 0;

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_ten = 0; m_conf = 0; m_forced = 0;
        m_cpu_pend = 1'b0; m_dsk_pend = 1'b0;
        cpu_exp_q.delete(); dsk_exp_q.delete();
        cpu_acc_flag = 1'b0; dsk_acc_flag = 1'b0;
    endtask

    initial begin
        int n_owner, n_last, n_ten, n_conf, n_forced;
        logic e_cg, e_dg, n_cpu_pend, n_dsk_pend, rel, forced, wr_en;
        logic [AW-1:0] wr_a;
        logic [DW-1:0] wr_d;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                continue;
            end
            e_cg = (m_owner == 1) && cpu_req;
            e_dg = (m_owner == 2) && dsk_req;
            check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
            check("dsk_gnt", 32'(dsk_gnt), 32'(e_dg));
            check("busy", 32'(busy), 32'(m_owner != 0));
            if (e_cg) begin
                check("mem_addr", 32'(mem_addr), 32'(cpu_addr));
                check("mem_data", 32'(mem_data), 32'(cpu_wdata));
                check("mem_we", 32'(mem_we), 32'(cpu_we));
            end else if (e_dg) begin
                check("mem_addr", 32'(mem_addr), 32'(dsk_addr));
                check("mem_data", 32'(mem_data), 32'(dsk_wdata));
                check("mem_we", 32'(mem_we), 32'(dsk_we));
            end else begin
                check("idle_we", 32'(mem_we), 32'd0);
                check("idle_addr", 32'(mem_addr), 32'd0);
                check("idle_data", 32'(mem_data), 32'd0);
            end
            check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_pend));
            if (m_cpu_pend) begin
                if (cpu_exp_q.size() == 0) check("cpu_exp_q", 32'd0, 32'd1);
                else check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
            end
            check("dsk_rvalid", 32'(dsk_rvalid), 32'(m_dsk_pend));
            if (m_dsk_pend) begin
                if (dsk_exp_q.size() == 0) check("dsk_exp_q", 32'd0, 32'd1);
                else check("dsk_rdata", 32'(dsk_rdata), 32'(dsk_exp_q.pop_front()));
            end
`ifdef MEM_ARB_STATS_EN
            check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
            check("forced_cnt", 32'(forced_cnt), 32'(m_forced));
`endif
            cpu_acc_flag = e_cg;
            dsk_acc_flag = e_dg;
            if (e_dg) dsk_acc_n++;
            n_cpu_pend = e_cg && !cpu_we;
            n_dsk_pend = e_dg && !dsk_we;
            if (n_cpu_pend) cpu_exp_q.push_back(shadow_rd(cpu_addr));
            if (n_dsk_pend) dsk_exp_q.push_back(shadow_rd(dsk_addr));
            wr_en = (e_cg && cpu_we) || (e_dg && dsk_we);
            wr_a  = e_cg ? cpu_addr : dsk_addr;
            wr_d  = e_cg ? cpu_wdata : dsk_wdata;

            n_owner = m_owner; n_last = m_last; n_ten = m_ten; forced = 1'b0;
            case (m_owner)
                0: begin
                    if (cpu_req && dsk_req) n_owner = (m_last == 2) ? 1 : 2;
                    else if (cpu_req)       n_owner = 1;
                    else if (dsk_req)       n_owner = 2;
                end
                1: begin
                    n_owner = dsk_req ? 2 : 0;
                    n_last  = 1;
                end
                default: begin
                    rel = 1'b1;
                    if (dsk_req) begin
                        n_ten  = m_ten + 1;
                        forced = dsk_lock && cpu_req && (n_ten >= MAX_BURST);
                        rel    = !dsk_lock || forced;
                    end
                    if (rel) begin
                        n_owner = cpu_req ? 1 : 0;
                        n_last  = 2;
                        n_ten   = 0;
                    end
                end
            endcase
            n_conf   = m_conf;
            n_forced = m_forced;
            if (((m_owner == 1 && dsk_req) || (m_owner == 2 && cpu_req)) && m_conf < 65535)
                n_conf = m_conf + 1;
            if (forced && m_forced < 255) n_forced = m_forced + 1;

            @(posedge clk);
            if (!rst) begin
                m_owner = n_owner; m_last = n_last; m_ten = n_ten;
                m_conf = n_conf; m_forced = n_forced;
                m_cpu_pend = n_cpu_pend; m_dsk_pend = n_dsk_pend;
                if (wr_en) shadow[int'(wr_a)] = wr_d;
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    int cpu_waits;
    int cpu_acc_cyc_t, dsk_acc_cyc_t;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waits;
        logic ok;
        waits = 0; ok = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        while (waits < 400) begin
            @(posedge clk);
            waits++;
            ok = cpu_acc_flag;
            if (rst || ok) break;
        end
        cpu_waits = waits;
        cpu_acc_cyc_t = cyc;
        #1;
        cpu_req = 1'b0;
        if (!ok && !rst) check("cpu_timeout", 32'd0, 32'd1);
    endtask

    task automatic dsk_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic lock);
        int waits;
        logic ok;
        waits = 0; ok = 1'b0;
        dsk_req = 1'b1; dsk_we = we; dsk_addr = a; dsk_wdata = d; dsk_lock = lock;
        while (waits < 400) begin
            @(posedge clk);
            waits++;
            ok = dsk_acc_flag;
            if (rst || ok) break;
        end
        dsk_acc_cyc_t = cyc;
        #1;
        dsk_req = 1'b0; dsk_lock = 1'b0;
        if (!ok && !rst) check("dsk_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        #1;
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dsk_gnt", 32'(dsk_gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rvalid", 32'({cpu_rvalid, dsk_rvalid}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // simultaneous requests after reset: CPU wins the first tie
        fork
            cpu_access(1'b0, 16'h0020, 16'h0000);
            dsk_access(1'b0, 16'h0021, 16'h0000, 1'b0);
        join
        check("tie_order", 32'(dsk_acc_cyc_t - cpu_acc_cyc_t), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // lone CPU read: granted one cycle after the request
        cpu_access(1'b0, 16'h0010, 16'h0000);
        check("t1_latency", 32'(cpu_waits), 32'd2);
        @(negedge clk);
        check("t1_rvalid", 32'(cpu_rvalid), 32'd1);
        check("t1_rdata", 32'(cpu_rdata), 32'h1234);
        check("t1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // disk write then CPU read-back
        dsk_access(1'b1, 16'h0200, 16'hBEEF, 1'b0);
        cpu_access(1'b0, 16'h0200, 16'h0000);
        @(negedge clk);
        check("t4_rdata", 32'(cpu_rdata), 32'hBEEF);
        @(posedge clk);
        #1;

        // locked burst forced to release after MAX_BURST accesses
        base = dsk_acc_n;
        fork
            begin
                for (int i = 0; i < 12; i++) dsk_access(1'b0, 16'(16'h0100 + i), 16'h0000, i != 11);
            end
            begin
                wait (dsk_acc_n >= base + 2);
                @(posedge clk);
                #1;
                cpu_access(1'b0, 16'h0030, 16'h0000);
                check("t3_burst_len", 32'(dsk_acc_n - base), 32'(MAX_BURST));
            end
        join
`ifdef MEM_ARB_STATS_EN
        check("t3_forced", 32'(forced_cnt), 32'd1);
`endif
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a locked read burst
        base = dsk_acc_n;
        fork
            begin
                for (int i = 0; i < 20 && !rst; i++) dsk_access(1'b0, 16'(i), 16'h0000, 1'b1);
            end
            begin
                wait (dsk_acc_n >= base + 3);
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check("t5_dsk_gnt", 32'(dsk_gnt), 32'd0);
                check("t5_dsk_rvalid", 32'(dsk_rvalid), 32'd0);
                check("t5_mem_we", 32'(mem_we), 32'd0);
                check("t5_busy", 32'(busy), 32'd0);
            end
        join
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fork
            cpu_access(1'b1, 16'h0040, 16'h5A5A);
            dsk_access(1'b1, 16'h0041, 16'hA5A5, 1'b0);
        join
        check("t5_tie_order", 32'(dsk_acc_cyc_t - cpu_acc_cyc_t), 32'd1);

        // randomized traffic
        fork
            begin
                int g;
                for (int i = 0; i < 80; i++) begin
                    g = $urandom_range(0, 3);
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                    cpu_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)),
                               16'($urandom));
                end
            end
            begin
                int g;
                for (int i = 0; i < 120; i++) begin
                    g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                    dsk_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)),
                               16'($urandom), $urandom_range(0, 3) != 0);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("cpu_q_drained", 32'(cpu_exp_q.size()), 32'd0);
        check("dsk_q_drained", 32'(dsk_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
